// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, reset fetch address,
// the NOP encoding shown to decode when nothing is buffered, and the
// fetch FSM state encoding.
package pipeline_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          FIFO_DEPTH     = 2;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between the fetch FSM and decode.
// The head entry is read straight out of registers; when the buffer is
// empty the head reads as a NOP at address 0 so decode never sees X.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic                  head_valid,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    // A pop only counts when something is there; a push into a full
    // buffer is only accepted when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop && (count != 2'd0);
        push_ok = push && ((count != 2'd2) || pop_ok);
    end

    // Pointers and occupancy; flush empties the buffer like a reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Entry storage needs no reset: occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    // Present the head entry, or a NOP at address 0 when empty.
    always_comb begin
        head_valid = (count != 2'd0);
        head_pc    = '0;
        head_instr = DATA_WIDTH'(NOP_INSTR);
        if (head_valid) begin
            head_pc    = pc_mem[rd_ptr];
            head_instr = instr_mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: keeps a single memory read outstanding, buffers
// returned words in a two-entry FIFO and redirects on taken branches.
// A response that belongs to a cancelled fetch is swallowed in DROP.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int                   DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] fetch_pc_next;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic [1:0]            count;
    logic                  redirect;
    logic                  accept;
    logic                  req_issue;
    logic                  fifo_push;

    // Decode handshake; a branch only counts when its instruction is taken.
    always_comb begin
        accept          = instr_valid && instr_ready;
        redirect        = accept && PCsrc;
        redirect_target = instr_pc + ImmOp;
    end

    // Next state and fetch address. A redirect seen in REQ suppresses the
    // request so no response for the old path is ever left in flight.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_issue     = 1'b0;
        fifo_push     = 1'b0;
        case (state)
            FETCH_REQ: begin
                if (!redirect && (count < 2'd2)) begin
                    req_issue  = 1'b1;
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_next = FETCH_REQ;
                    if (!redirect) begin
                        fifo_push     = 1'b1;
                        fetch_pc_next = fetch_pc + DATA_WIDTH'(4);
                    end
                end else if (redirect) begin
                    state_next = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid) begin
                    state_next = FETCH_REQ;
                end
            end
            default: begin
                state_next = FETCH_REQ;
            end
        endcase
        if (redirect) begin
            fetch_pc_next = redirect_target;
        end
    end

    // State register and fetch PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH_REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Requests are held off while reset is asserted.
    always_comb begin
        imem_req  = req_issue && rst_n;
        imem_addr = fetch_pc;
    end

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_pc    (fetch_pc),
        .push_instr (imem_rdata),
        .pop        (accept),
        .flush      (redirect),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .head_valid (instr_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory
// with programmable latency, and a scoreboard of expected decode pcs.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int checks;
    int errors;
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;

    logic        mem_auto;
    int          mem_wait;
    logic        mem_rv;
    logic [31:0] mem_rd;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic        force_rv;
    logic [31:0] force_rd;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign imem_rvalid = force_rv | mem_rv;
    assign imem_rdata  = force_rv ? force_rd : mem_rd;

    // Memory model: a request seen in a cycle is answered mem_wait cycles
    // after the following one; rvalid is updated on the falling edge.
    always @(negedge clk) begin
        if (!mem_auto) begin
            pend   <= 1'b0;
            mem_rv <= 1'b0;
        end else begin
            mem_rv <= 1'b0;
            if (pend && pend_cnt == 0) begin
                mem_rv <= 1'b1;
                mem_rd <= memword(pend_addr);
                pend   <= 1'b0;
            end else if (pend) begin
                pend_cnt <= pend_cnt - 1;
            end
            if (imem_req && rst_n) begin
                pend      <= 1'b1;
                pend_addr <= imem_addr;
                pend_cnt  <= mem_wait;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        force_rv    = 1'b0;
        mem_auto    = 1'b0;
        mem_wait    = 0;
        exp_q.delete();
        repeat (3) next_cycle();
        rst_n    = 1'b1;
        mem_auto = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'h0;
        force_rv = 1'b0; force_rd = 32'h0; mem_auto = 1'b0; mem_wait = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 ||
            instr !== NOP || instr_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: req=%b addr=%h valid=%b instr=%h pc=%h, required 0 %h 0 %h 0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, RESET_PC, NOP);
        end
        next_cycle();
        rst_n = 1'b1; mem_auto = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL first_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_cycle: req=%b valid=%b, required 0 0", imem_req, instr_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== memword(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL first_instr: valid=%b pc=%h instr=%h, required 1 %h %h",
                     instr_valid, instr_pc, instr, RESET_PC, memword(RESET_PC));
        end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== ((k % 2) == 0) || (imem_req && imem_addr !== 32'(k * 2))) begin
                errors++;
                $display("[TB] FAIL stream_req: cycle %0d req=%b addr=%h, required %b %h",
                         k, imem_req, imem_addr, (k % 2) == 0, 32'(k * 2));
            end
            if (k == 2) begin
                checks++;
                if (instr_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stream_latency: valid=%b, required 1", instr_valid);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stream_pop: got pc %h, required none", instr_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (instr_pc !== exp_pc || instr !== memword(exp_pc)) begin
                        errors++;
                        $display("[TB] FAIL stream_pop: pc=%h instr=%h, required %h %h",
                                 instr_pc, instr, exp_pc, memword(exp_pc));
                    end
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stream_drain: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        int reqs;
        logic first;
        do_reset();
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_req) reqs++;
            if (k == 9) begin
                checks++;
                if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: req=%b valid=%b pc=%h, required 0 1 0",
                             imem_req, instr_valid, instr_pc);
                end
            end
            next_cycle();
        end
        checks++;
        if (reqs != 2) begin
            errors++;
            $display("[TB] FAIL stall_reqs: %0d requests, required 2", reqs);
        end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        instr_ready = 1'b1;
        first = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            if (imem_req && first) begin
                first = 1'b0;
                checks++;
                if (imem_addr !== 32'h8) begin
                    errors++;
                    $display("[TB] FAIL stall_resume: addr=%h, required 00000008", imem_addr);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                exp_pc = exp_q.pop_front();
                if (instr_pc !== exp_pc || instr !== memword(exp_pc)) begin
                    errors++;
                    $display("[TB] FAIL stall_pop: pc=%h instr=%h, required %h %h",
                             instr_pc, instr, exp_pc, memword(exp_pc));
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0 || first) begin
            errors++;
            $display("[TB] FAIL stall_drain: %0d left resumed=%b, required 0 1", exp_q.size(), !first);
        end
    endtask

    task automatic test_redirect_wait();
        int phase;
        int rc;
        do_reset();
        mem_wait = 2;
        phase = 0;
        rc = -10;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
            PCsrc = 1'b0;
            if (phase == 0 && instr_valid && instr_pc == 32'h10) begin
                instr_ready = 1'b0;
                phase = 1;
            end else if (phase == 1) begin
                instr_ready = 1'b1;
                PCsrc = 1'b1;
                ImmOp = 32'hFFFF_FFF8;
                phase = 2;
                rc = k;
            end else begin
                instr_ready = 1'b1;
            end
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                checks++;
                exp_pc = exp_q.pop_front();
                if (instr_pc !== exp_pc || instr !== memword(exp_pc)) begin
                    errors++;
                    $display("[TB] FAIL drop_pop: pc=%h instr=%h, required %h %h",
                             instr_pc, instr, exp_pc, memword(exp_pc));
                end
            end
            if (k == rc + 1 || k == rc + 2) begin
                checks++;
                if (imem_req !== 1'b0 || (k == rc + 1 && instr_valid !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL drop_quiet: cycle +%0d req=%b valid=%b, required 0 0",
                             k - rc, imem_req, instr_valid);
                end
            end
            if (k == rc + 3) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                    errors++;
                    $display("[TB] FAIL drop_target: req=%b addr=%h, required 1 00000008", imem_req, imem_addr);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0 || phase != 2) begin
            errors++;
            $display("[TB] FAIL drop_drain: %0d left phase=%0d, required 0 2", exp_q.size(), phase);
        end
    endtask

    // Scripted redirect after reset: pc 0 is presented in cycle 2; the
    // redirect is taken in cycle rcyc. Checks the first request after it.
    task automatic run_redirect(input string name, input int rcyc, input logic [31:0] imm,
                                input logic [31:0] tgt, input logic [31:0] tgt2);
        logic seen;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(tgt); exp_q.push_back(tgt2);
        seen = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            instr_ready = (k >= rcyc);
            PCsrc = 1'b0;
            if (k == 2) begin
                PCsrc = 1'b1;
                ImmOp = 32'h100;
            end
            if (k == rcyc) begin
                PCsrc = 1'b1;
                ImmOp = imm;
            end
            @(negedge clk);
            if (k == rcyc) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || (rcyc == 2 && imem_req !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL %s_at: valid=%b pc=%h req=%b, required 1 0 %b",
                             name, instr_valid, instr_pc, imem_req, rcyc != 2);
                end
            end
            if (k == rcyc + 1) begin
                checks++;
                if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== tgt) begin
                    errors++;
                    $display("[TB] FAIL %s_next: valid=%b req=%b addr=%h, required 0 1 %h",
                             name, instr_valid, imem_req, imem_addr, tgt);
                end
            end
            if (k > rcyc + 1 && imem_req && !seen) begin
                seen = 1'b1;
                checks++;
                if (imem_addr !== tgt + 32'd4) begin
                    errors++;
                    $display("[TB] FAIL %s_seq: addr=%h, required %h", name, imem_addr, tgt + 32'd4);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                exp_pc = exp_q.pop_front();
                if (instr_pc !== exp_pc || instr !== memword(exp_pc)) begin
                    errors++;
                    $display("[TB] FAIL %s_pop: pc=%h instr=%h, required %h %h",
                             name, instr_pc, instr, exp_pc, memword(exp_pc));
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d left, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_redirect_rvalid();
        run_redirect("redir_rvalid", 3, 32'h20, 32'h20, 32'h24);
    endtask

    task automatic test_redirect_req();
        run_redirect("redir_req", 2, 32'h40, 32'h40, 32'h44);
    endtask

    task automatic test_wrap();
        run_redirect("wrap", 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_wait = 5;
        next_cycle();
        rst_n = 1'b0;
        mem_auto = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        mem_auto = 1'b1;
        mem_wait = 0;
        force_rv = 1'b1;
        force_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL rstwait_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
        end
        next_cycle();
        force_rv = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwait_stale: valid=%b instr=%h, required 0", instr_valid, instr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== memword(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL rstwait_fresh: valid=%b pc=%h instr=%h, required 1 %h %h",
                     instr_valid, instr_pc, instr, RESET_PC, memword(RESET_PC));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_req();
        test_wrap();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
